// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes, RV32I opcode/funct7 constants and decode field bundle
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] ALU_NONE  = 6'd0;
    localparam logic [5:0] ALU_ADD   = 6'd1;
    localparam logic [5:0] ALU_SUB   = 6'd2;
    localparam logic [5:0] ALU_SLL   = 6'd3;
    localparam logic [5:0] ALU_SLT   = 6'd4;
    localparam logic [5:0] ALU_SLTU  = 6'd5;
    localparam logic [5:0] ALU_XOR   = 6'd6;
    localparam logic [5:0] ALU_SRL   = 6'd7;
    localparam logic [5:0] ALU_SRA   = 6'd8;
    localparam logic [5:0] ALU_OR    = 6'd9;
    localparam logic [5:0] ALU_AND   = 6'd10;
    localparam logic [5:0] ALU_ADDI  = 6'd11;
    localparam logic [5:0] ALU_SLLI  = 6'd12;
    localparam logic [5:0] ALU_SLTI  = 6'd13;
    localparam logic [5:0] ALU_SLTIU = 6'd14;
    localparam logic [5:0] ALU_XORI  = 6'd15;
    localparam logic [5:0] ALU_SRLI  = 6'd16;
    localparam logic [5:0] ALU_SRAI  = 6'd17;
    localparam logic [5:0] ALU_ORI   = 6'd18;
    localparam logic [5:0] ALU_ANDI  = 6'd19;
    localparam logic [5:0] ALU_LUI   = 6'd20;
    localparam logic [5:0] ALU_BEQ   = 6'd21;
    localparam logic [5:0] ALU_BNE   = 6'd22;
    localparam logic [5:0] ALU_BLT   = 6'd23;
    localparam logic [5:0] ALU_BGE   = 6'd24;
    localparam logic [5:0] ALU_BLTU  = 6'd25;
    localparam logic [5:0] ALU_BGEU  = 6'd26;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [5:0]  alu_control;
        logic [31:0] imm;
        logic [3:0]  shamt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        is_branch;
        logic        illegal;
    } dec_fields_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV32I instruction-word to ALU operation field decoder
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_fields_t fields_o
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [5:0]  op;
    logic [31:0] imm;
    logic        legal;
    logic        wr;
    logic        br;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        op    = ALU_NONE;
        imm   = '0;
        legal = 1'b1;
        wr    = 1'b0;
        br    = 1'b0;
        case (opcode)
            OP_R: begin
                wr = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  op = ALU_ADD;
                        3'b001:  op = ALU_SLL;
                        3'b010:  op = ALU_SLT;
                        3'b011:  op = ALU_SLTU;
                        3'b100:  op = ALU_XOR;
                        3'b101:  op = ALU_SRL;
                        3'b110:  op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    op = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_I: begin
                wr  = 1'b1;
                imm = sext12(instr_i[31:20]);
                case (funct3)
                    3'b000: op = ALU_ADDI;
                    3'b010: op = ALU_SLTI;
                    3'b011: op = ALU_SLTIU;
                    3'b100: op = ALU_XORI;
                    3'b110: op = ALU_ORI;
                    3'b111: op = ALU_ANDI;
                    // Shift port is 4 bits wide, so shamt bit 4 cannot be honoured
                    3'b001: begin
                        op    = ALU_SLLI;
                        legal = (funct7 == F7_BASE) && !instr_i[24];
                    end
                    default: begin
                        op    = (funct7 == F7_ALT) ? ALU_SRAI : ALU_SRLI;
                        legal = !instr_i[24] && (funct7 == F7_BASE || funct7 == F7_ALT);
                    end
                endcase
            end
            OP_LUI: begin
                wr  = 1'b1;
                op  = ALU_LUI;
                imm = {instr_i[31:12], 12'b0};
            end
            OP_BR: begin
                br  = 1'b1;
                imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                       instr_i[11:8], 1'b0};
                case (funct3)
                    3'b000:  op = ALU_BEQ;
                    3'b001:  op = ALU_BNE;
                    3'b100:  op = ALU_BLT;
                    3'b101:  op = ALU_BGE;
                    3'b110:  op = ALU_BLTU;
                    3'b111:  op = ALU_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        fields_o.rs1   = instr_i[19:15];
        fields_o.rs2   = instr_i[24:20];
        fields_o.rd    = instr_i[11:7];
        fields_o.shamt = instr_i[23:20];
        if (legal) begin
            fields_o.alu_control = op;
            fields_o.imm         = imm;
            fields_o.reg_write   = wr;
            fields_o.is_branch   = br;
            fields_o.illegal     = 1'b0;
        end else begin
            fields_o.alu_control = ALU_NONE;
            fields_o.imm         = '0;
            fields_o.reg_write   = 1'b0;
            fields_o.is_branch   = 1'b0;
            fields_o.illegal     = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with valid/ready handshake, flush and sticky illegal flag
module decode_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      alu_control,
    output logic [XLEN-1:0] imm_val_r,
    output logic [3:0]      shamt,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            is_branch,
    output logic            illegal,
    output logic            illegal_seen
);

    dec_fields_t dec;
    dec_fields_t ent_d, ent_q;
    logic        out_valid_d, out_valid_q;
    logic        seen_d, seen_q;
    logic        accept;

    alu_op_decode u_dec (
        .instr_i  (in_instr),
        .fields_o (dec)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Flush wins over accept: the word arriving alongside it never lands
    always_comb begin
        out_valid_d = out_valid_q;
        ent_d       = ent_q;
        seen_d      = seen_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            ent_d       = dec;
            seen_d      = seen_q | dec.illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            seen_q      <= 1'b0;
            ent_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            seen_q      <= seen_d;
            ent_q       <= ent_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign illegal_seen = seen_q;
    assign alu_control  = ent_q.alu_control;
    assign imm_val_r    = ent_q.imm;
    assign shamt        = ent_q.shamt;
    assign rs1          = ent_q.rs1;
    assign rs2          = ent_q.rs2;
    assign rd           = ent_q.rd;
    assign reg_write    = ent_q.reg_write;
    assign is_branch    = ent_q.is_branch;
    assign illegal      = ent_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage against a behavioural RV32I decode model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, imm_val_r;
    logic [5:0]  alu_control;
    logic [3:0]  shamt;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, is_branch, illegal, illegal_seen;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .imm_val_r(imm_val_r), .shamt(shamt),
        .rs1(rs1), .rs2(rs2), .rd(rd), .reg_write(reg_write), .is_branch(is_branch),
        .illegal(illegal), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  alu;
        logic [31:0] imm;
        logic [3:0]  sh;
        logic [4:0]  r1, r2, rdst;
        logic        rw, br, ill;
    } exp_t;

    localparam int R_TAB [0:7] = '{1, 3, 4, 5, 6, 7, 9, 10};
    localparam int I_TAB [0:7] = '{11, 12, 13, 14, 15, 16, 18, 19};
    localparam int B_TAB [0:7] = '{21, 22, 0, 0, 23, 24, 25, 26};

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;
    bit   held = 0, exp_seen = 0;
    bit   last_acc = 0, last_fl = 0, last_rdy = 0, last_ill = 0;

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t        e;
        int          f3, f7;
        bit          ok;
        logic [31:0] t;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        ok = 1;
        e.r1 = w[19:15]; e.r2 = w[24:20]; e.rdst = w[11:7]; e.sh = w[23:20];
        e.alu = 0; e.imm = 0; e.rw = 0; e.br = 0; e.ill = 0;
        case (w[6:0])
            7'h33: begin
                e.rw = 1;
                if (f7 == 0) e.alu = 6'(R_TAB[f3]);
                else if (f7 == 32 && f3 == 0) e.alu = 2;
                else if (f7 == 32 && f3 == 5) e.alu = 8;
                else ok = 0;
            end
            7'h13: begin
                e.rw  = 1;
                e.imm = $signed(w) >>> 20;
                if (f3 == 1) begin
                    ok = (f7 == 0) && !w[24]; e.alu = 12;
                end else if (f3 == 5) begin
                    ok = !w[24] && (f7 == 0 || f7 == 32); e.alu = (f7 == 32) ? 6'd17 : 6'd16;
                end else e.alu = 6'(I_TAB[f3]);
            end
            7'h37: begin
                e.rw = 1; e.alu = 20; e.imm = w & 32'hFFFFF000;
            end
            7'h63: begin
                e.br = 1;
                t = {w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0};
                e.imm = $signed(t) >>> 19;
                if (f3 == 2 || f3 == 3) ok = 0;
                else e.alu = 6'(B_TAB[f3]);
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e.alu = 0; e.imm = 0; e.rw = 0; e.br = 0; e.ill = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k <= 2) w[6:0] = 7'h33;
        else if (k <= 5) w[6:0] = 7'h13;
        else if (k == 6) w[6:0] = 7'h37;
        else if (k <= 8) w[6:0] = 7'h63;
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
        if ($urandom_range(0, 1) == 1) w[24] = 1'b0;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whatever is presented must equal the scoreboard head; pop on consume
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("alu_control", 32'(alu_control), 32'(sb[0].alu));
                chk("imm_val_r", imm_val_r, sb[0].imm);
                chk("shamt", 32'(shamt), 32'(sb[0].sh));
                chk("rs1", 32'(rs1), 32'(sb[0].r1));
                chk("rs2", 32'(rs2), 32'(sb[0].r2));
                chk("rd", 32'(rd), 32'(sb[0].rdst));
                chk("reg_write", 32'(reg_write), 32'(sb[0].rw));
                chk("is_branch", 32'(is_branch), 32'(sb[0].br));
                chk("illegal", 32'(illegal), 32'(sb[0].ill));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        exp_t e;
        bit   acc;
        @(posedge clk);
        #1;
        if (last_fl) begin
            held = 0;
            sb.delete();
        end else if (last_acc) begin
            held = 1;
            if (last_ill) exp_seen = 1;
        end else if (last_rdy) held = 0;
        in_valid = v; in_instr = ins; out_ready = rdy; flush = fl;
        #2;
        chk("in_ready", 32'(in_ready), 32'(!held || rdy));
        chk("out_valid", 32'(out_valid), 32'(held));
        chk("illegal_seen", 32'(illegal_seen), 32'(exp_seen));
        e   = ref_decode(ins);
        acc = v && (!held || rdy);
        if (acc && !fl) sb.push_back(e);
        last_acc = acc; last_fl = fl; last_rdy = rdy; last_ill = e.ill;
    endtask

    task automatic dir_vec(input logic [31:0] ins);
        step(1, ins, 1, 0);
        step(0, 32'h0, 1, 0);
        chk("dir_out_valid", 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_instr = 0; flush = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal_seen", 32'(illegal_seen), 32'd0);
        chk("rst_alu", 32'(alu_control), 32'd0);
        chk("rst_imm", imm_val_r, 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_rw", 32'(reg_write), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1;

        dir_vec(32'h002081B3);
        chk("add_alu", 32'(alu_control), 32'd1);
        chk("add_rd", 32'(rd), 32'd3);
        chk("add_rs1", 32'(rs1), 32'd1);
        chk("add_rs2", 32'(rs2), 32'd2);
        chk("add_rw", 32'(reg_write), 32'd1);
        dir_vec(32'hFFF10093);
        chk("addi_alu", 32'(alu_control), 32'd11);
        chk("addi_imm", imm_val_r, 32'hFFFFFFFF);
        dir_vec(32'h4030D093);
        chk("srai_alu", 32'(alu_control), 32'd17);
        chk("srai_shamt", 32'(shamt), 32'd3);
        dir_vec(32'h123450B7);
        chk("lui_alu", 32'(alu_control), 32'd20);
        chk("lui_imm", imm_val_r, 32'h12345000);
        dir_vec(32'hFE208EE3);
        chk("beq_alu", 32'(alu_control), 32'd21);
        chk("beq_imm", imm_val_r, 32'hFFFFFFFC);
        chk("beq_br", 32'(is_branch), 32'd1);
        chk("beq_rw", 32'(reg_write), 32'd0);

        // Backpressure: held entry stays put, then back-to-back accepts
        step(1, 32'h00310133, 1, 0);
        repeat (3) step(1, 32'h40208233, 0, 0);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        step(1, 32'h40208233, 1, 0);
        for (int i = 0; i < 6; i++) step(1, rand_instr(), 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        dir_vec(32'h01F09093);
        chk("slli31_illegal", 32'(illegal), 32'd1);
        chk("slli31_alu", 32'(alu_control), 32'd0);
        chk("slli31_seen", 32'(illegal_seen), 32'd1);
        dir_vec(32'h0000000B);
        chk("custom_illegal", 32'(illegal), 32'd1);
        chk("custom_alu", 32'(alu_control), 32'd0);

        step(1, 32'h002081B3, 1, 0);
        step(1, 32'h00000013, 0, 1);
        step(1, 32'h00000013, 1, 1);
        step(0, 32'h0, 1, 0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 7), rand_instr(), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0));
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        // Asynchronous reset mid-operation, then a flushed illegal word must not set the flag
        step(1, 32'h002081B3, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 0;
        in_valid = 0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_seen", 32'(illegal_seen), 32'd0);
        sb.delete();
        held = 0; exp_seen = 0; last_acc = 0; last_fl = 0; last_rdy = 0; last_ill = 0;
        @(negedge clk);
        rst_n = 1;
        step(1, 32'h0000000B, 1, 1);
        step(0, 32'h0, 1, 0);
        chk("flushed_illegal_seen", 32'(illegal_seen), 32'd0);
        step(0, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage that produces the operation interface consumed by the ALU: `alu_control`, `imm_val_r`, `shamt`, and the register specifiers and control flags around them. It accepts 32-bit RV32I instruction words from fetch over a valid/ready handshake and decodes them into one pipeline register. It holds that register under execute-side backpressure and supports a flush for taken branches. It sits between instruction fetch and the register file / ALU.

## Interface
- `XLEN`, 32, datapath and instruction width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents an instruction word.
- `in_ready`  out  1  stage can accept the word this cycle.
- `in_instr`  in  32  instruction word.
- `flush`  in  1  discard the held entry and the current input.
- `out_valid`  out  1  decoded entry is valid.
- `out_ready`  in  1  execute consumes the entry.
- `alu_control`  out  6  ALU operation code; 0 means none.
- `imm_val_r`  out  32  decoded immediate.
- `shamt`  out  4  shift amount, taken from `in_instr[23:20]`.
- `rs1`, `rs2`, `rd`  out  5 each  register specifiers.
- `reg_write`  out  1  the instruction writes `rd`.
- `is_branch`  out  1  the instruction is a conditional branch.
- `illegal`  out  1  the held entry is unsupported.
- `illegal_seen`  out  1  sticky flag; set when any illegal entry is accepted.

## Operation
- ALU op codes:
  - ADD 1, SUB 2, SLL 3, SLT 4, SLTU 5, XOR 6, SRL 7, SRA 8, OR 9, AND 10
  - ADDI 11, SLLI 12, SLTI 13, SLTIU 14, XORI 15, SRLI 16, SRAI 17, ORI 18, ANDI 19
  - LUI 20, BEQ 21, BNE 22, BLT 23, BGE 24, BLTU 25, BGEU 26
- R-type, opcode 0110011:
  - funct3/funct7 select ADD…AND.
  - funct7 0100000 is allowed only with funct3 000 (SUB) and 101 (SRA).
  - Any other funct7 other than 0000000 is illegal.
- I-type ALU, opcode 0010011:
  - funct3 000/010/011/100/110/111 map to ADDI/SLTI/SLTIU/XORI/ORI/ANDI.
  - Immediate is `in_instr[31:20]`, sign-extended.
  - funct3 001 is SLLI; it requires funct7 0000000.
  - funct3 101 is SRLI with funct7 0000000, or SRAI with funct7 0100000.
  - On any shift, `in_instr[24]=1` is illegal, because the ALU shift port is 4 bits.
- LUI, opcode 0110111: `imm_val_r = {in_instr[31:12], 12'b0}`.
- Branch, opcode 1100011:
  - funct3 000/001/100/101/110/111 map to BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - B-immediate is sign-extended with bit 0 = 0.
  - funct3 010 and 011 are illegal.
  - `reg_write=0`, `is_branch=1`.
- `reg_write=1` for R-type, I-type and LUI. When it is 0, `rd` is still driven from `in_instr[11:7]`.
- Illegal or unknown opcode: `alu_control=0`, `reg_write=0`, `is_branch=0`, `imm_val_r=0`, `illegal=1`. The entry is still registered and handed to execute.

## Timing
- Reset: `out_valid=0`, `illegal_seen=0`, and all payload outputs 0. Reset asserted mid-operation drops the held entry immediately.
- `in_ready = !out_valid || out_ready`. It is combinational and has no dependence on `in_valid`.
- Accept when `in_valid && in_ready`. The decoded entry appears on the next rising edge with `out_valid=1`. Latency is 1 cycle.
- Consume with no new accept: `out_valid` falls on the next edge.
- Consume and accept in the same cycle: the new entry replaces the old one. Full throughput is 1 instruction per cycle.
- When `out_valid && !out_ready`, all outputs hold stable and `in_ready=0`.
- `flush` has priority over everything. On the next edge `out_valid=0`. Any word accepted in that cycle is discarded and `illegal_seen` is not updated by it.
- The payload registers do not need to clear when `out_valid=0`. Only `out_valid` is architecturally meaningful.
- `illegal_seen` is set on the edge that accepts an illegal word and stays set until reset.

## Structure
- Shared package `alu_pkg` holds:
  - the 26 ALU op-code localparams (6 bits);
  - opcode constants `OP_R`, `OP_I`, `OP_LUI`, `OP_BR`;
  - the funct7 constants.
- The ALU uses the same package.
- Sub-module `alu_op_decode`: purely combinational instruction-to-fields decoder. `decode_stage` wraps it with the handshake register, flush and the sticky flag.

## Test plan
- Reset, then `in_instr=0x002081B3` (add x3,x1,x2) with `in_valid=1` and `out_ready=1` → next cycle `out_valid=1`, `alu_control=1`, `rd=3`, `rs1=1`, `rs2=2`, `reg_write=1`.
- `0xFFF10093` (addi x1,x2,-1) → `alu_control=11`, `imm_val_r=0xFFFFFFFF`. `0x4030D093` (srai x1,x1,3) → `alu_control=17`, `shamt=3`.
- `0x123450B7` (lui x1,0x12345) → `alu_control=20`, `imm_val_r=0x12345000`. `0xFE208EE3` (beq, −4) → `alu_control=21`, `imm_val_r=0xFFFFFFFC`, `is_branch=1`, `reg_write=0`.
- Hold `out_ready=0` for 3 cycles while `in_valid=1` → `in_ready=0` and outputs stable. Release → back-to-back accepts, one per cycle, with no lost or duplicated entry.
- `0x01F09093` (slli shamt 31) and `0x0000000B` (custom opcode) → `illegal=1`, `alu_control=0`, `illegal_seen=1`. Then `flush` with `in_valid=1` → `out_valid=0` on the next cycle.
